// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - state encoding and per-state quarter counts for the I2C master
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ADDR      = 4'd2,
        ST_ADDR_ACK  = 4'd3,
        ST_WRITE     = 4'd4,
        ST_WRITE_ACK = 4'd5,
        ST_READ      = 4'd6,
        ST_READ_NACK = 4'd7,
        ST_STOP      = 4'd8
    } i2c_state_t;

    localparam logic [5:0] START_QUARTERS = 6'd2;
    localparam logic [5:0] BYTE_QUARTERS  = 6'd32;
    localparam logic [5:0] ACK_QUARTERS   = 6'd4;
    localparam logic [5:0] STOP_QUARTERS  = 6'd3;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1110010;

    function automatic logic [5:0] state_quarters(input i2c_state_t s);
        case (s)
            ST_START:                                return START_QUARTERS;
            ST_ADDR, ST_WRITE, ST_READ:              return BYTE_QUARTERS;
            ST_ADDR_ACK, ST_WRITE_ACK, ST_READ_NACK: return ACK_QUARTERS;
            ST_STOP:                                 return STOP_QUARTERS;
            default:                                 return 6'd1;
        endcase
    endfunction

    function automatic logic is_byte_state(input i2c_state_t s);
        return (s == ST_ADDR) || (s == ST_WRITE) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - CLK_DIV divider emitting a one-cycle SCL quarter tick
module i2c_quarter_tick #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int unsigned W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || !enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && !restart && (cnt == LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        sda,
    inout  wire        scl
);

    i2c_state_t state, state_n;
    logic [5:0] q, q_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] addr_byte, data_l, rx;
    logic       nack, sda_low, scl_low;
    logic       tick, accept, last_q, bit_end, tx_bit;

    assign accept = (state == ST_IDLE) && !busy && start;
    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign scl    = scl_low ? 1'b0 : 1'bz;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .enable  (state != ST_IDLE),
        .tick    (tick)
    );

    // Returns {scl_low, sda_low} for the quarter about to be entered.
    function automatic logic [1:0] line_drive(input i2c_state_t s, input logic [5:0] qq, input logic bit_v);
        case (s)
            ST_START:           return {1'b0, qq[0]};
            ST_STOP:            return {qq == 6'd0, qq != 6'd2};
            ST_ADDR, ST_WRITE:  return {!qq[1], !bit_v};
            ST_ADDR_ACK, ST_WRITE_ACK,
            ST_READ, ST_READ_NACK: return {!qq[1], 1'b0};
            default:            return 2'b00;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        q_n       = q;
        bit_cnt_n = bit_cnt;
        last_q    = (q == state_quarters(state) - 6'd1);
        bit_end   = tick && (q[1:0] == 2'd3);
        if (accept) begin
            state_n = ST_START;
            q_n     = '0;
        end else if (tick) begin
            q_n = last_q ? 6'd0 : q + 6'd1;
            if (last_q) begin
                case (state)
                    ST_START:     state_n = ST_ADDR;
                    ST_ADDR:      state_n = ST_ADDR_ACK;
                    ST_ADDR_ACK:  state_n = nack ? ST_STOP : (addr_byte[0] ? ST_READ : ST_WRITE);
                    ST_WRITE:     state_n = ST_WRITE_ACK;
                    ST_READ:      state_n = ST_READ_NACK;
                    ST_WRITE_ACK,
                    ST_READ_NACK: state_n = ST_STOP;
                    default:      state_n = ST_IDLE;
                endcase
            end
        end
        if (state_n != state) begin
            bit_cnt_n = 3'd7;
        end else if (bit_end && is_byte_state(state)) begin
            bit_cnt_n = bit_cnt - 3'd1;
        end
        tx_bit = (state_n == ST_WRITE) ? data_l[bit_cnt_n] : addr_byte[bit_cnt_n];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            q         <= '0;
            bit_cnt   <= 3'd7;
            addr_byte <= '0;
            data_l    <= '0;
            rx        <= '0;
            nack      <= 1'b0;
            sda_low   <= 1'b0;
            scl_low   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
            data_rd   <= '0;
        end else begin
            state              <= state_n;
            q                  <= q_n;
            bit_cnt            <= bit_cnt_n;
            {scl_low, sda_low} <= line_drive(state_n, q_n, tx_bit);
            done               <= 1'b0;
            if (accept) begin
                busy      <= 1'b1;
                ack_err   <= 1'b0;
                nack      <= 1'b0;
                addr_byte <= {addr, rw};
                data_l    <= data_wr;
            end else if (done) begin
                busy <= 1'b0;
            end
            // SDA is sampled on the Q2->Q3 tick, mid SCL-high.
            if (tick && q[1:0] == 2'd2) begin
                if ((state == ST_ADDR_ACK || state == ST_WRITE_ACK) && sda) nack <= 1'b1;
                if (state == ST_READ) rx <= {rx[6:0], sda};
            end
            if (tick && last_q) begin
                if (state == ST_READ_NACK) data_rd <= rx;
                if (state == ST_STOP) begin
                    done    <= 1'b1;
                    ack_err <= nack;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - self-checking bench for i2c_master_ctrl with a behavioural slave
`timescale 1ns/1ps
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int unsigned CLK_DIV = 4;
    localparam int FULL_CYC = 77 * CLK_DIV;
    localparam int NACK_CYC = 41 * CLK_DIV;
    localparam logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] data_wr = '0;
    logic [7:0] data_rd;
    logic       busy, done, ack_err;
    wire        sda, scl;
    logic       slave_low = 1'b0;

    pullup (sda);
    pullup (scl);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .data_wr (data_wr),
        .data_rd (data_rd),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .sda     (sda),
        .scl     (scl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_checks = 0, n_fail = 0;
    logic [7:0] exp_rd = '0, exp_in = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Behavioural slave at DEFAULT_SLAVE_ADDR plus a bus monitor, oversampling the lines.
    logic [7:0] data_in = '0, data_slave = '0, sl_sh = '0;
    logic       sl_active = 1'b0, sl_match = 1'b0, sl_read = 1'b0;
    int         sl_bit = 0, starts = 0, stops = 0;
    logic       obs[$];

    initial begin
        logic scl_c, sda_c, scl_p, sda_p;
        int   f, p;
        scl_p = 1'b1;
        sda_p = 1'b1;
        forever begin
            @(negedge clk);
            scl_c = scl;
            sda_c = sda;
            if (scl_c && scl_p && sda_p && !sda_c) begin
                starts++;
                sl_active = 1'b1;
                sl_bit    = 0;
                slave_low = 1'b0;
            end else if (scl_c && scl_p && !sda_p && sda_c) begin
                stops++;
                sl_active = 1'b0;
                slave_low = 1'b0;
            end else if (sl_active && scl_c && !scl_p) begin
                f = sl_bit / 9;
                p = sl_bit % 9;
                obs.push_back(sda_c);
                if (p < 8 && (f == 0 || (f == 1 && !sl_read))) sl_sh = {sl_sh[6:0], sda_c};
                if (p == 7 && f == 0) begin
                    sl_match = (sl_sh[7:1] == SLAVE_ADDR);
                    sl_read  = sl_sh[0];
                end
                if (p == 7 && f == 1 && !sl_read && sl_match) data_in = sl_sh;
                sl_bit++;
            end else if (sl_active && !scl_c && scl_p) begin
                f = sl_bit / 9;
                p = sl_bit % 9;
                if (p == 8 && (f == 0 || (f == 1 && !sl_read))) slave_low = sl_match;
                else if (f == 1 && p < 8 && sl_read && sl_match) slave_low = !data_slave[3'(7 - p)];
                else slave_low = 1'b0;
            end
            scl_p = scl_c;
            sda_p = sda_c;
        end
    end

    task automatic apply_txn(input string tag, input logic [6:0] a, input logic r, input logic [7:0] d,
                             input logic [7:0] ds, input logic e_err, input int e_cyc,
                             input logic [7:0] e_rd, input logic [7:0] e_in);
        int          t0, got_cyc, e_n;
        logic [18:0] e_bits, g_bits;
        // Bits seen at each SCL rise; the STOP's SCL rise shows up as a final clock with SDA low.
        e_n    = e_err ? 10 : 19;
        e_bits = e_err ? {a, r, 1'b1, 1'b0, 9'b0} : {a, r, 1'b0, (r ? ds : d), r, 1'b0};
        @(negedge clk);
        data_slave = ds;
        addr = a; rw = r; data_wr = d; start = 1'b1;
        starts = 0; stops = 0;
        obs.delete();
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0; addr = ~a; rw = ~r; data_wr = ~d;
        check({tag, " busy"}, 32'(busy), 32'd1);
        got_cyc = -1;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin
                got_cyc = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done_cycles"}, 32'(got_cyc), 32'(e_cyc));
        check({tag, " ack_err"}, 32'(ack_err), 32'(e_err));
        check({tag, " data_rd"}, 32'(data_rd), 32'(e_rd));
        check({tag, " slave_data_in"}, 32'(data_in), 32'(e_in));
        check({tag, " bus_bit_count"}, 32'(obs.size()), 32'(e_n));
        g_bits = '0;
        for (int i = 0; i < obs.size() && i < 19; i++) g_bits[18 - i] = obs[i];
        check({tag, " bus_bits"}, 32'(g_bits), 32'(e_bits));
        check({tag, " start_conditions"}, 32'(starts), 32'd1);
        check({tag, " stop_conditions"}, 32'(stops), 32'd1);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'({done, busy}), 32'd0);
        exp_rd = e_rd;
        exp_in = e_in;
    endtask

    typedef struct {
        string      name;
        logic [6:0] a;
        logic       r;
        logic [7:0] d;
        logic [7:0] ds;
        logic       e_err;
        int         e_cyc;
        logic [7:0] e_rd;
        logic [7:0] e_in;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         t0, ndone, got;
        logic [6:0] a;
        logic       r, e_err;
        logic [7:0] d, ds;

        vecs[0] = '{"write_a5",   7'h72, 1'b0, 8'hA5, 8'h00, 1'b0, FULL_CYC, 8'h00, 8'hA5};
        vecs[1] = '{"read_b3",    7'h72, 1'b1, 8'h00, 8'hB3, 1'b0, FULL_CYC, 8'hB3, 8'hA5};
        vecs[2] = '{"bad_addr_w", 7'h15, 1'b0, 8'h5A, 8'h00, 1'b1, NACK_CYC, 8'hB3, 8'hA5};
        vecs[3] = '{"bad_addr_r", 7'h15, 1'b1, 8'h00, 8'h77, 1'b1, NACK_CYC, 8'hB3, 8'hA5};
        vecs[4] = '{"write_00",   7'h72, 1'b0, 8'h00, 8'h00, 1'b0, FULL_CYC, 8'hB3, 8'h00};
        vecs[5] = '{"read_ff",    7'h72, 1'b1, 8'h12, 8'hFF, 1'b0, FULL_CYC, 8'hFF, 8'h00};

        repeat (3) @(negedge clk);
        check("reset sda", 32'(sda), 32'd1);
        check("reset scl", 32'(scl), 32'd1);
        check("reset busy_done_err", 32'({busy, done, ack_err}), 32'd0);
        check("reset data_rd", 32'(data_rd), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i])
            apply_txn(vecs[i].name, vecs[i].a, vecs[i].r, vecs[i].d, vecs[i].ds,
                      vecs[i].e_err, vecs[i].e_cyc, vecs[i].e_rd, vecs[i].e_in);

        for (int k = 0; k < 16; k++) begin
            a  = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom_range(0, 127));
            r  = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            ds = 8'($urandom_range(0, 255));
            e_err = (a != SLAVE_ADDR);
            apply_txn("random", a, r, d, ds, e_err, e_err ? NACK_CYC : FULL_CYC,
                      (!e_err && r) ? ds : exp_rd, (!e_err && !r) ? d : exp_in);
        end

        // Reset at quarter 20 of ADDR, then a clean write.
        @(negedge clk);
        addr = SLAVE_ADDR; rw = 1'b0; data_wr = 8'h3C; start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 22 * CLK_DIV + 1) @(negedge clk);
        check("midreset scl_low_before", 32'(scl), 32'd0);
        rst = 1'b1;
        #1;
        check("midreset lines_released", 32'({scl, sda}), 32'd3);
        check("midreset busy", 32'(busy), 32'd0);
        ndone = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < FULL_CYC; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midreset no_done", 32'(ndone), 32'd0);
        check("midreset data_in_kept", 32'(data_in), 32'(exp_in));
        exp_rd = 8'h00;
        apply_txn("post_reset_write", SLAVE_ADDR, 1'b0, 8'h3C, 8'h00, 1'b0, FULL_CYC, 8'h00, 8'h3C);

        // start pulsed while busy must be ignored.
        @(negedge clk);
        addr = SLAVE_ADDR; rw = 1'b0; data_wr = 8'h96; start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        got = -1;
        for (int i = 0; i < FULL_CYC + 60; i++) begin
            if (i == 100) begin start = 1'b1; addr = 7'h15; rw = 1'b1; data_wr = 8'h11; end
            if (i == 101) start = 1'b0;
            if (done) begin
                ndone++;
                if (got < 0) got = cyc - t0;
            end
            @(negedge clk);
        end
        check("busy_start single_done", 32'(ndone), 32'd1);
        check("busy_start done_cycles", 32'(got), 32'(FULL_CYC));
        check("busy_start data_in", 32'(data_in), 32'h96);
        check("busy_start ack_err", 32'(ack_err), 32'd0);

        // start held through done is re-accepted the cycle after done.
        @(negedge clk);
        addr = SLAVE_ADDR; rw = 1'b0; data_wr = 8'h5C; start = 1'b1;
        got = 0;
        for (int i = 0; i < FULL_CYC + 20; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        check("held_start first_done", 32'(got), 32'd1);
        @(negedge clk);
        check("held_start gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("held_start reaccept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < FULL_CYC + 20; i++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        check("held_start second_done", 32'(got), 32'd1);
        check("held_start data_in", 32'(data_in), 32'h5C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
